zion_basic_circuit_lib_skid_reg: RTL and testbench



---
 rtl/zion_basic_circuit_lib_skid_reg.sv | 143 ++++++++++++++
 tb/tb_zion_basic_circuit_lib_skid_reg.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/zion_basic_circuit_lib_skid_reg.sv
// Valid/ready pipeline register with a one-entry skid buffer; every output comes straight from a flop.
// A companion checker module holds the simulation-only protocol properties.

module zion_basic_circuit_lib_skid_reg #(
    parameter int unsigned             WIDTH    = 8,
    parameter logic [WIDTH-1:0]        INI_DATA = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             iClr,
    input  logic             iVld,
    output logic             oRdy,
    input  logic [WIDTH-1:0] iDat,
    output logic             oVld,
    input  logic             iRdy,
    output logic [WIDTH-1:0] oDat,
    output logic             oFull
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t           state_r;
    logic [WIDTH-1:0] main_r;
    logic [WIDTH-1:0] skid_r;
    logic             vld_r;
    logic             rdy_r;
    logic             full_r;
    logic             acc_s;
    logic             tk_s;

    assign acc_s = iVld & rdy_r;
    assign tk_s  = vld_r & iRdy;

    // Flow-control FSM; status outputs are registered alongside the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_EMPTY;
            main_r  <= INI_DATA;
            skid_r  <= INI_DATA;
            vld_r   <= 1'b0;
            rdy_r   <= 1'b0;
            full_r  <= 1'b0;
        end else if (iClr) begin
            state_r <= ST_EMPTY;
            main_r  <= INI_DATA;
            skid_r  <= INI_DATA;
            vld_r   <= 1'b0;
            rdy_r   <= 1'b1;
            full_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    rdy_r <= 1'b1;
                    if (acc_s) begin
                        main_r  <= iDat;
                        vld_r   <= 1'b1;
                        state_r <= ST_ONE;
                    end else begin
                        vld_r   <= 1'b0;
                    end
                end
                ST_ONE: begin
                    if (acc_s && tk_s) begin
                        main_r  <= iDat;
                        rdy_r   <= 1'b1;
                    end else if (acc_s) begin
                        // Consumer stalled: park the new beat so the head stays put.
                        skid_r  <= iDat;
                        full_r  <= 1'b1;
                        rdy_r   <= 1'b0;
                        state_r <= ST_FULL;
                    end else if (tk_s) begin
                        vld_r   <= 1'b0;
                        rdy_r   <= 1'b1;
                        state_r <= ST_EMPTY;
                    end else begin
                        rdy_r   <= 1'b1;
                    end
                end
                ST_FULL: begin
                    if (tk_s) begin
                        main_r  <= skid_r;
                        full_r  <= 1'b0;
                        rdy_r   <= 1'b1;
                        state_r <= ST_ONE;
                    end else begin
                        rdy_r   <= 1'b0;
                    end
                end
                default: begin
                    state_r <= ST_EMPTY;
                    main_r  <= INI_DATA;
                    skid_r  <= INI_DATA;
                    vld_r   <= 1'b0;
                    rdy_r   <= 1'b1;
                    full_r  <= 1'b0;
                end
            endcase
        end
    end

    assign oRdy  = rdy_r;
    assign oVld  = vld_r;
    assign oDat  = main_r;
    assign oFull = full_r;

    zion_basic_circuit_lib_skid_reg_chk #(
        .WIDTH (WIDTH)
    ) u_chk (
        .clk   (clk),
        .rst_n (rst_n),
        .oRdy  (rdy_r),
        .oVld  (vld_r),
        .oFull (full_r)
    );

endmodule

// Protocol properties of the skid register, evaluated in simulation only.
module zion_basic_circuit_lib_skid_reg_chk #(
    parameter int unsigned WIDTH = 8
) (
    input logic clk,
    input logic rst_n,
    input logic oRdy,
    input logic oVld,
    input logic oFull
);

    a_width_ok: assert property (@(posedge clk) WIDTH >= 32'd1)
        else $error("skid_reg: WIDTH must be at least 1");

    a_full_not_rdy: assert property (@(posedge clk) disable iff (!rst_n) !(oFull && oRdy))
        else $error("skid_reg: oFull and oRdy both high");

    a_full_implies_vld: assert property (@(posedge clk) disable iff (!rst_n) (!oFull || oVld))
        else $error("skid_reg: oFull without oVld");

endmodule

// File: tb/tb_zion_basic_circuit_lib_skid_reg.sv
// Directed bench for the skid register: reset, streaming, back-pressure, random flow, clear, async reset.

module tb_zion_basic_circuit_lib_skid_reg;

    localparam int unsigned WIDTH = 8;
    localparam logic [WIDTH-1:0] INI = 8'h00;

    logic             clk;
    logic             rst_n;
    logic             iClr;
    logic             iVld;
    logic             oRdy;
    logic [WIDTH-1:0] iDat;
    logic             oVld;
    logic             iRdy;
    logic [WIDTH-1:0] oDat;
    logic             oFull;

    int checks;
    int failures;

    zion_basic_circuit_lib_skid_reg #(
        .WIDTH    (WIDTH),
        .INI_DATA (INI)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .iClr  (iClr),
        .iVld  (iVld),
        .oRdy  (oRdy),
        .iDat  (iDat),
        .oVld  (oVld),
        .iRdy  (iRdy),
        .oDat  (oDat),
        .oFull (oFull)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [WIDTH-1:0] q[$];
        logic [WIDTH-1:0] cnt;
        logic [WIDTH-1:0] prev_dat;
        logic [WIDTH-1:0] exp_dat;
        logic             prev_stall;
        logic             acc;
        logic             tk;
        int               sent;
        int               recv;
        int               cyc;

        checks   = 0;
        failures = 0;
        rst_n = 1'b0; iClr = 1'b0; iVld = 1'b0; iRdy = 1'b0; iDat = 8'h00;

        // 1: reset values, then oRdy rises on the first edge after release
        repeat (3) tick();
        chk("rst_vld", {31'd0, oVld}, 32'd0);
        chk("rst_rdy", {31'd0, oRdy}, 32'd0);
        chk("rst_full", {31'd0, oFull}, 32'd0);
        chk("rst_dat", {24'd0, oDat}, {24'd0, INI});
        rst_n = 1'b1;
        tick();
        chk("rel_rdy", {31'd0, oRdy}, 32'd1);
        chk("rel_vld", {31'd0, oVld}, 32'd0);

        // 2: streaming at full rate
        iRdy = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            iVld = 1'b1;
            iDat = 8'(i);
            tick();
            chk("str_dat", {24'd0, oDat}, 32'(i));
            chk("str_vld", {31'd0, oVld}, 32'd1);
            chk("str_rdy", {31'd0, oRdy}, 32'd1);
            chk("str_full", {31'd0, oFull}, 32'd0);
        end
        iVld = 1'b0;
        tick();
        chk("str_drain_vld", {31'd0, oVld}, 32'd0);

        // 3: back-pressure into the skid entry
        iRdy = 1'b0; iVld = 1'b1; iDat = 8'hA1;
        tick();
        chk("bp_a1_dat", {24'd0, oDat}, 32'hA1);
        chk("bp_a1_rdy", {31'd0, oRdy}, 32'd1);
        chk("bp_a1_full", {31'd0, oFull}, 32'd0);
        iDat = 8'hA2;
        tick();
        chk("bp_full", {31'd0, oFull}, 32'd1);
        chk("bp_rdy0", {31'd0, oRdy}, 32'd0);
        chk("bp_hold_dat", {24'd0, oDat}, 32'hA1);
        iDat = 8'hA3;
        tick();
        chk("bp_ignored_dat", {24'd0, oDat}, 32'hA1);
        chk("bp_still_full", {31'd0, oFull}, 32'd1);
        iVld = 1'b0; iRdy = 1'b1;
        tick();
        chk("bp_a2_dat", {24'd0, oDat}, 32'hA2);
        chk("bp_a2_rdy", {31'd0, oRdy}, 32'd1);
        chk("bp_a2_full", {31'd0, oFull}, 32'd0);
        tick();
        chk("bp_empty_vld", {31'd0, oVld}, 32'd0);

        // 4: random valid/ready with an in-order scoreboard
        cnt = 8'h00; sent = 0; recv = 0; cyc = 0;
        prev_stall = 1'b0; prev_dat = 8'h00;
        while ((recv < 2000) && (cyc < 20000)) begin
            if (prev_stall) begin
                chk("rnd_stall_vld", {31'd0, oVld}, 32'd1);
                chk("rnd_stall_dat", {24'd0, oDat}, {24'd0, prev_dat});
            end
            iVld = (sent < 2000) ? 1'($urandom_range(0, 1)) : 1'b0;
            iRdy = 1'($urandom_range(0, 3) != 0);
            iDat = cnt;
            acc = iVld && oRdy;
            tk  = oVld && iRdy;
            if (tk) begin
                exp_dat = (q.size() > 0) ? q.pop_front() : 8'hxx;
                chk("rnd_dat", {24'd0, oDat}, {24'd0, exp_dat});
                recv++;
            end
            if (acc) begin
                q.push_back(cnt);
                cnt = cnt + 8'd1;
                sent++;
            end
            prev_stall = oVld && !iRdy;
            prev_dat   = oDat;
            tick();
            cyc++;
        end
        chk("rnd_recv_count", 32'(recv), 32'd2000);
        chk("rnd_queue_empty", 32'(q.size()), 32'd0);
        iVld = 1'b0; iRdy = 1'b1;
        tick();
        chk("rnd_end_vld", {31'd0, oVld}, 32'd0);

        // 5: clear in FULL beats a simultaneous accept and take
        iRdy = 1'b0; iVld = 1'b1; iDat = 8'hB1;
        tick();
        iDat = 8'hB2;
        tick();
        chk("clr_pre_full", {31'd0, oFull}, 32'd1);
        iClr = 1'b1; iVld = 1'b1; iRdy = 1'b1; iDat = 8'hB3;
        tick();
        chk("clr_vld", {31'd0, oVld}, 32'd0);
        chk("clr_full", {31'd0, oFull}, 32'd0);
        chk("clr_rdy", {31'd0, oRdy}, 32'd1);
        chk("clr_dat", {24'd0, oDat}, {24'd0, INI});
        iClr = 1'b0; iVld = 1'b0;
        tick();
        chk("clr_no_deliver", {31'd0, oVld}, 32'd0);

        // 6: asynchronous reset while stalled in FULL
        iRdy = 1'b0; iVld = 1'b1; iDat = 8'hC1;
        tick();
        iDat = 8'hC2;
        tick();
        chk("ar_pre_full", {31'd0, oFull}, 32'd1);
        iVld = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_vld", {31'd0, oVld}, 32'd0);
        chk("ar_full", {31'd0, oFull}, 32'd0);
        chk("ar_rdy", {31'd0, oRdy}, 32'd0);
        chk("ar_dat", {24'd0, oDat}, {24'd0, INI});
        tick();
        rst_n = 1'b1;
        tick();
        chk("ar_rel_rdy", {31'd0, oRdy}, 32'd1);
        chk("ar_rel_vld", {31'd0, oVld}, 32'd0);
        iRdy = 1'b1; iVld = 1'b1; iDat = 8'hD1;
        tick();
        chk("ar_d1", {24'd0, oDat}, 32'hD1);
        iDat = 8'hD2;
        tick();
        chk("ar_d2", {24'd0, oDat}, 32'hD2);
        chk("ar_d2_vld", {31'd0, oVld}, 32'd1);
        iVld = 1'b0;
        tick();
        chk("ar_end_vld", {31'd0, oVld}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
